// File: rtl/mips_multicycle_control.sv
// Multi-cycle MIPS main control FSM: sequences fetch/decode/execute/memory/writeback
// with a memory ready handshake. Optional memory-timeout fault guarded by MC_TIMEOUT_EN.
module mips_multicycle_control #(
    parameter int OPCODE_W    = 6,
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                mem_ready,
    output logic                pcWrite,
    output logic                pcWriteCond,
    output logic                iorD,
    output logic                memRead,
    output logic                memWrite,
    output logic                irWrite,
    output logic                memToReg,
    output logic                regDst,
    output logic                regWrite,
    output logic                aluSrcA,
    output logic [1:0]          aluSrcB,
    output logic [1:0]          aluOp,
    output logic [1:0]          pcSource,
    output logic                illegal,
    output logic                fault,
    output logic [CNT_W-1:0]    retired,
    output logic [3:0]          state
);

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        FETCH  = 4'd1,
        DECODE = 4'd2,
        MEMADR = 4'd3,
        MEMRD  = 4'd4,
        MEMWB  = 4'd5,
        MEMWR  = 4'd6,
        EXEC   = 4'd7,
        ALUWB  = 4'd8,
        BRANCH = 4'd9,
        JUMP   = 4'd10,
        ADDIEX = 4'd11,
        ADDIWB = 4'd12,
        FAULT  = 4'd13
    } stateT;

    localparam logic [OPCODE_W-1:0] OP_R    = OPCODE_W'(6'h00);
    localparam logic [OPCODE_W-1:0] OP_LW   = OPCODE_W'(6'h23);
    localparam logic [OPCODE_W-1:0] OP_SW   = OPCODE_W'(6'h2B);
    localparam logic [OPCODE_W-1:0] OP_BEQ  = OPCODE_W'(6'h04);
    localparam logic [OPCODE_W-1:0] OP_J    = OPCODE_W'(6'h02);
    localparam logic [OPCODE_W-1:0] OP_ADDI = OPCODE_W'(6'h08);

    stateT curState, nextState;
    logic  retireEvt;
    logic  memWait;

    assign state = curState;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            curState <= IDLE;
            retired  <= '0;
        end else begin
            curState <= nextState;
            if (retireEvt)
                retired <= retired + 1'b1;
        end
    end

`ifdef MC_TIMEOUT_EN
    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

    logic [WAIT_W-1:0] waitCnt;
    logic              timedOut;

    assign timedOut = memWait && (waitCnt == WAIT_W'(MEM_TIMEOUT - 1));

    // Counts consecutive stalled cycles; any state change restarts the count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            waitCnt <= '0;
        else if (memWait && nextState == curState)
            waitCnt <= waitCnt + 1'b1;
        else
            waitCnt <= '0;
    end

    assign fault = (curState == FAULT);
`else
    logic timedOut;
    logic unusedTimeoutParam;

    assign timedOut           = 1'b0;
    assign unusedTimeoutParam = ^MEM_TIMEOUT;
    assign fault              = 1'b0;
`endif

    assign memWait = (curState == FETCH || curState == MEMRD || curState == MEMWR) && !mem_ready;

    always_comb begin
        nextState   = curState;
        retireEvt   = 1'b0;
        pcWrite     = 1'b0;
        pcWriteCond = 1'b0;
        iorD        = 1'b0;
        memRead     = 1'b0;
        memWrite    = 1'b0;
        irWrite     = 1'b0;
        memToReg    = 1'b0;
        regDst      = 1'b0;
        regWrite    = 1'b0;
        aluSrcA     = 1'b0;
        aluSrcB     = 2'b00;
        aluOp       = 2'b00;
        pcSource    = 2'b00;
        illegal     = 1'b0;

        unique case (curState)
            IDLE: nextState = FETCH;
            FETCH: begin
                memRead = 1'b1;
                aluSrcB = 2'b01;
                if (mem_ready) begin
                    irWrite   = 1'b1;
                    pcWrite   = 1'b1;
                    nextState = DECODE;
                end else if (timedOut) begin
                    nextState = FAULT;
                end
            end
            DECODE: begin
                aluSrcB = 2'b11;
                if (opcode == OP_R)
                    nextState = EXEC;
                else if (opcode == OP_LW || opcode == OP_SW)
                    nextState = MEMADR;
                else if (opcode == OP_BEQ)
                    nextState = BRANCH;
                else if (opcode == OP_J)
                    nextState = JUMP;
                else if (opcode == OP_ADDI)
                    nextState = ADDIEX;
                else begin
                    illegal   = 1'b1;
                    nextState = FETCH;
                end
            end
            MEMADR: begin
                aluSrcA   = 1'b1;
                aluSrcB   = 2'b10;
                nextState = (opcode == OP_LW) ? MEMRD : MEMWR;
            end
            MEMRD: begin
                iorD    = 1'b1;
                memRead = 1'b1;
                if (mem_ready)
                    nextState = MEMWB;
                else if (timedOut)
                    nextState = FAULT;
            end
            MEMWB: begin
                memToReg  = 1'b1;
                regWrite  = 1'b1;
                nextState = FETCH;
                retireEvt = 1'b1;
            end
            MEMWR: begin
                iorD     = 1'b1;
                memWrite = 1'b1;
                if (mem_ready) begin
                    nextState = FETCH;
                    retireEvt = 1'b1;
                end else if (timedOut) begin
                    nextState = FAULT;
                end
            end
            EXEC: begin
                aluSrcA   = 1'b1;
                aluOp     = 2'b10;
                nextState = ALUWB;
            end
            ALUWB: begin
                regDst    = 1'b1;
                regWrite  = 1'b1;
                nextState = FETCH;
                retireEvt = 1'b1;
            end
            BRANCH: begin
                aluSrcA     = 1'b1;
                aluOp       = 2'b01;
                pcWriteCond = 1'b1;
                pcSource    = 2'b01;
                nextState   = FETCH;
                retireEvt   = 1'b1;
            end
            JUMP: begin
                pcWrite   = 1'b1;
                pcSource  = 2'b10;
                nextState = FETCH;
                retireEvt = 1'b1;
            end
            ADDIEX: begin
                aluSrcA   = 1'b1;
                aluSrcB   = 2'b10;
                nextState = ADDIWB;
            end
            ADDIWB: begin
                regWrite  = 1'b1;
                nextState = FETCH;
                retireEvt = 1'b1;
            end
            // Only reset leaves FAULT; fault itself is decoded from the state.
            FAULT: nextState = FAULT;
            default: nextState = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Directed testbench for mips_multicycle_control with hand-computed per-cycle expectations.
// Timeout checks are compiled in when MC_TIMEOUT_EN is defined.
module tb_mips_multicycle_control;

    localparam logic [3:0] S_IDLE = 4'd0, S_FETCH = 4'd1, S_DECODE = 4'd2, S_MEMADR = 4'd3,
                           S_MEMRD = 4'd4, S_MEMWB = 4'd5, S_MEMWR = 4'd6, S_EXEC = 4'd7,
                           S_ALUWB = 4'd8, S_BRANCH = 4'd9, S_JUMP = 4'd10, S_ADDIEX = 4'd11,
                           S_ADDIWB = 4'd12, S_FAULT = 4'd13;

    // Packed control order: pcWrite pcWriteCond iorD memRead memWrite irWrite memToReg regDst
    // regWrite aluSrcA aluSrcB[1:0] aluOp[1:0] pcSource[1:0] illegal fault
    localparam logic [17:0] C_IDLE      = 18'b0;
    localparam logic [17:0] C_FETCH_RDY = {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 1'b0, 1'b0};
    localparam logic [17:0] C_FETCH_WT  = {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 1'b0, 1'b0};
    localparam logic [17:0] C_DECODE    = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 2'b00, 2'b00, 1'b0, 1'b0};
    localparam logic [17:0] C_DEC_ILL   = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 2'b00, 2'b00, 1'b1, 1'b0};
    localparam logic [17:0] C_MEMADR    = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0};
    localparam logic [17:0] C_MEMRD     = {1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0};
    localparam logic [17:0] C_MEMWB     = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0};
    localparam logic [17:0] C_MEMWR     = {1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0};
    localparam logic [17:0] C_EXEC      = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b10, 2'b00, 1'b0, 1'b0};
    localparam logic [17:0] C_ALUWB     = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0};
    localparam logic [17:0] C_BRANCH    = {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b01, 2'b01, 1'b0, 1'b0};
    localparam logic [17:0] C_JUMP      = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b10, 1'b0, 1'b0};
    localparam logic [17:0] C_ADDIWB    = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0};
    localparam logic [17:0] C_FAULT     = 18'b1;

    logic        clk;
    logic        rst;
    logic [5:0]  opcode;
    logic        memReady;
    logic        pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite;
    logic        memToReg, regDst, regWrite, aluSrcA, illegal, fault;
    logic [1:0]  aluSrcB, aluOp, pcSource;
    logic [31:0] retired;
    logic [3:0]  state;
    logic [17:0] ctrl;

    int compared   = 0;
    int mismatched = 0;

    mips_multicycle_control #(.OPCODE_W(6), .CNT_W(32), .MEM_TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(memReady),
        .pcWrite(pcWrite), .pcWriteCond(pcWriteCond), .iorD(iorD), .memRead(memRead),
        .memWrite(memWrite), .irWrite(irWrite), .memToReg(memToReg), .regDst(regDst),
        .regWrite(regWrite), .aluSrcA(aluSrcA), .aluSrcB(aluSrcB), .aluOp(aluOp),
        .pcSource(pcSource), .illegal(illegal), .fault(fault), .retired(retired), .state(state)
    );

    assign ctrl = {pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite, memToReg, regDst,
                   regWrite, aluSrcA, aluSrcB, aluOp, pcSource, illegal, fault};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [3:0] expState, input logic [17:0] expCtrl);
        compared++;
        assert (state === expState) else begin
            mismatched++;
            $error("[TB] FAIL %s state: observed %0d expected %0d", tag, state, expState);
        end
        compared++;
        assert (ctrl === expCtrl) else begin
            mismatched++;
            $error("[TB] FAIL %s ctrl: observed %b expected %b", tag, ctrl, expCtrl);
        end
    endtask

    task automatic checkRetired(input string tag, input logic [31:0] expRetired);
        compared++;
        assert (retired === expRetired) else begin
            mismatched++;
            $error("[TB] FAIL %s retired: observed %0d expected %0d", tag, retired, expRetired);
        end
    endtask

    // Drives one cycle's inputs, checks mid-cycle, then advances just past the next rising edge.
    task automatic applyStimulus(input string tag, input logic rdy, input logic [5:0] op,
                                 input logic [3:0] expState, input logic [17:0] expCtrl);
        memReady = rdy;
        opcode   = op;
        #2;
        checkOutput(tag, expState, expCtrl);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst      = 1'b0;
        memReady = 1'b1;
        opcode   = 6'h00;
        #1;
        for (int i = 0; i < 3; i++) begin
            applyStimulus("reset", 1'b1, 6'h00, S_IDLE, C_IDLE);
            checkRetired("reset", 32'd0);
        end
        rst = 1'b1;
        applyStimulus("idle", 1'b1, 6'h00, S_IDLE, C_IDLE);

        // R-type: 4 cycles
        applyStimulus("r.fetch", 1'b1, 6'h00, S_FETCH, C_FETCH_RDY);
        checkRetired("r.start", 32'd0);
        applyStimulus("r.decode", 1'b1, 6'h00, S_DECODE, C_DECODE);
        applyStimulus("r.exec", 1'b1, 6'h00, S_EXEC, C_EXEC);
        applyStimulus("r.aluwb", 1'b1, 6'h00, S_ALUWB, C_ALUWB);

        // lw: 5 cycles
        applyStimulus("lw.fetch", 1'b1, 6'h23, S_FETCH, C_FETCH_RDY);
        checkRetired("lw.start", 32'd1);
        applyStimulus("lw.decode", 1'b1, 6'h23, S_DECODE, C_DECODE);
        applyStimulus("lw.memadr", 1'b1, 6'h23, S_MEMADR, C_MEMADR);
        applyStimulus("lw.memrd", 1'b1, 6'h23, S_MEMRD, C_MEMRD);
        applyStimulus("lw.memwb", 1'b1, 6'h23, S_MEMWB, C_MEMWB);

        // sw: 4 cycles
        applyStimulus("sw.fetch", 1'b1, 6'h2B, S_FETCH, C_FETCH_RDY);
        checkRetired("sw.start", 32'd2);
        applyStimulus("sw.decode", 1'b1, 6'h2B, S_DECODE, C_DECODE);
        applyStimulus("sw.memadr", 1'b1, 6'h2B, S_MEMADR, C_MEMADR);
        applyStimulus("sw.memwr", 1'b1, 6'h2B, S_MEMWR, C_MEMWR);

        // beq: 3 cycles
        applyStimulus("beq.fetch", 1'b1, 6'h04, S_FETCH, C_FETCH_RDY);
        checkRetired("beq.start", 32'd3);
        applyStimulus("beq.decode", 1'b1, 6'h04, S_DECODE, C_DECODE);
        applyStimulus("beq.branch", 1'b1, 6'h04, S_BRANCH, C_BRANCH);

        // j: 3 cycles
        applyStimulus("j.fetch", 1'b1, 6'h02, S_FETCH, C_FETCH_RDY);
        checkRetired("j.start", 32'd4);
        applyStimulus("j.decode", 1'b1, 6'h02, S_DECODE, C_DECODE);
        applyStimulus("j.jump", 1'b1, 6'h02, S_JUMP, C_JUMP);

        // addi: 4 cycles
        applyStimulus("addi.fetch", 1'b1, 6'h08, S_FETCH, C_FETCH_RDY);
        checkRetired("addi.start", 32'd5);
        applyStimulus("addi.decode", 1'b1, 6'h08, S_DECODE, C_DECODE);
        applyStimulus("addi.addiex", 1'b1, 6'h08, S_ADDIEX, C_MEMADR);
        applyStimulus("addi.addiwb", 1'b1, 6'h08, S_ADDIWB, C_ADDIWB);

        // lw with 3 wait cycles in MEMRD: 8 cycles total
        applyStimulus("lww.fetch", 1'b1, 6'h23, S_FETCH, C_FETCH_RDY);
        checkRetired("six.retired", 32'd6);
        applyStimulus("lww.decode", 1'b1, 6'h23, S_DECODE, C_DECODE);
        applyStimulus("lww.memadr", 1'b1, 6'h23, S_MEMADR, C_MEMADR);
        for (int i = 0; i < 3; i++)
            applyStimulus("lww.memrd.wait", 1'b0, 6'h23, S_MEMRD, C_MEMRD);
        applyStimulus("lww.memrd.rdy", 1'b1, 6'h23, S_MEMRD, C_MEMRD);
        applyStimulus("lww.memwb", 1'b1, 6'h23, S_MEMWB, C_MEMWB);

        // Illegal opcode pulses for one cycle and does not retire
        applyStimulus("ill.fetch", 1'b1, 6'h3F, S_FETCH, C_FETCH_RDY);
        checkRetired("ill.before", 32'd7);
        applyStimulus("ill.decode", 1'b1, 6'h3F, S_DECODE, C_DEC_ILL);
        applyStimulus("ill.refetch", 1'b1, 6'h00, S_FETCH, C_FETCH_RDY);
        checkRetired("ill.after", 32'd7);

        // Reset asserted while a store is waiting on memory
        applyStimulus("rsw.decode", 1'b1, 6'h2B, S_DECODE, C_DECODE);
        applyStimulus("rsw.memadr", 1'b1, 6'h2B, S_MEMADR, C_MEMADR);
        memReady = 1'b0;
        #2;
        checkOutput("rsw.memwr", S_MEMWR, C_MEMWR);
        rst = 1'b0;
        #1;
        checkOutput("rsw.async", S_IDLE, C_IDLE);
        checkRetired("rsw.async", 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        applyStimulus("rsw.idle", 1'b0, 6'h00, S_IDLE, C_IDLE);

`ifdef MC_TIMEOUT_EN
        for (int i = 0; i < 16; i++)
            applyStimulus("to.fetch.wait", 1'b0, 6'h00, S_FETCH, C_FETCH_WT);
        for (int i = 0; i < 3; i++)
            applyStimulus("to.fault", 1'b1, 6'h00, S_FAULT, C_FAULT);
        rst = 1'b0;
        #1;
        checkOutput("to.reset", S_IDLE, C_IDLE);
`else
        for (int i = 0; i < 20; i++)
            applyStimulus("nto.fetch.wait", 1'b0, 6'h00, S_FETCH, C_FETCH_WT);
        applyStimulus("nto.fetch.rdy", 1'b1, 6'h00, S_FETCH, C_FETCH_RDY);
        applyStimulus("nto.decode", 1'b1, 6'h00, S_DECODE, C_DECODE);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
